// File: rtl/alu16_sched.sv
// Round-robin scheduler sharing one alu16 between two valid/ready requesters.
// One operation in flight; operands are held for ALU_LAT cycles and the result returns on the winner's channel.
module alu16_sched #(
    parameter int ALU_LAT = 1,
    parameter int W       = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [3:0]   req0_op,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [3:0]   req1_op,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    output logic         resp0_valid,
    input  logic         resp0_ready,
    output logic [W-1:0] resp0_y,
    output logic [2:0]   resp0_flags,
    output logic         resp1_valid,
    input  logic         resp1_ready,
    output logic [W-1:0] resp1_y,
    output logic [2:0]   resp1_flags,
    output logic [3:0]   alu_op,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    input  logic [W-1:0] alu_y,
    input  logic         alu_z,
    input  logic         alu_c,
    input  logic         alu_v,
    output logic         busy,
    output logic         grant_id
);
    // state  | meaning
    // S_IDLE | arbitrating; ready shown only to the winner
    // S_WAIT | operands on the ALU, counting down its latency
    // S_RESP | result presented to the owner until it is taken

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    localparam logic [3:0] LAT_INIT = 4'(ALU_LAT);

    state_t       r_state;
    state_t       w_state_nxt;
    logic         r_last;
    logic         r_gid;
    logic [3:0]   r_cnt;
    logic [3:0]   r_alu_op;
    logic [W-1:0] r_alu_a;
    logic [W-1:0] r_alu_b;
    logic [W-1:0] r_y0;
    logic [W-1:0] r_y1;
    logic [2:0]   r_f0;
    logic [2:0]   r_f1;
    logic         w_gnt0;
    logic         w_gnt1;
    logic         w_accept;
    logic         w_capture;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gnt0      = 1'b0;
        w_gnt1      = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            S_IDLE: begin
                // On a tie the requester that did not win last time goes first.
                if (req0_valid && (!req1_valid || r_last)) begin
                    w_gnt0 = 1'b1;
                end else if (req1_valid) begin
                    w_gnt1 = 1'b1;
                end
                if (w_gnt0 || w_gnt1) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (r_gid ? resp1_ready : resp0_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_accept = w_gnt0 || w_gnt1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last   <= 1'b1;
            r_gid    <= 1'b0;
            r_cnt    <= 4'd0;
            r_alu_op <= 4'd0;
            r_alu_a  <= '0;
            r_alu_b  <= '0;
            r_y0     <= '0;
            r_y1     <= '0;
            r_f0     <= 3'd0;
            r_f1     <= 3'd0;
        end else begin
            if (w_accept) begin
                r_gid    <= w_gnt1;
                r_last   <= w_gnt1;
                r_cnt    <= LAT_INIT;
                r_alu_op <= w_gnt1 ? req1_op : req0_op;
                r_alu_a  <= w_gnt1 ? req1_a  : req0_a;
                r_alu_b  <= w_gnt1 ? req1_b  : req0_b;
            end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            // Response registers keep their value after valid drops.
            if (w_capture) begin
                if (r_gid) begin
                    r_y1 <= alu_y;
                    r_f1 <= {alu_z, alu_c, alu_v};
                end else begin
                    r_y0 <= alu_y;
                    r_f0 <= {alu_z, alu_c, alu_v};
                end
            end
        end
    end

    assign req0_ready  = w_gnt0;
    assign req1_ready  = w_gnt1;
    assign resp0_valid = (r_state == S_RESP) && !r_gid;
    assign resp1_valid = (r_state == S_RESP) &&  r_gid;
    assign resp0_y     = r_y0;
    assign resp1_y     = r_y1;
    assign resp0_flags = r_f0;
    assign resp1_flags = r_f1;
    assign alu_op      = r_alu_op;
    assign alu_a       = r_alu_a;
    assign alu_b       = r_alu_b;
    assign busy        = (r_state != S_IDLE);
    assign grant_id    = r_gid;

endmodule

// File: tb/tb_alu16_sched.sv
// Bench for alu16_sched: an ALU_LAT=1 instance checked every cycle against a transaction model,
// plus an ALU_LAT=3 instance with directed checks.
module tb_alu16_sched;
    localparam int W     = 16;
    localparam int LAT_A = 1;
    localparam int LAT_B = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   n_vec  = 0;
    int   n_miss = 0;
    bit   chk_en = 1'b0;

    logic         req0_valid, req1_valid, req0_ready, req1_ready;
    logic [3:0]   req0_op, req1_op;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         resp0_valid, resp1_valid, resp0_ready, resp1_ready;
    logic [W-1:0] resp0_y, resp1_y;
    logic [2:0]   resp0_flags, resp1_flags;
    logic [3:0]   alu_op;
    logic [W-1:0] alu_a, alu_b, alu_y;
    logic         alu_z, alu_c, alu_v, busy, grant_id;

    logic         b_req0_valid, b_req1_valid, b_req0_ready, b_req1_ready;
    logic [3:0]   b_req0_op, b_req1_op;
    logic [W-1:0] b_req0_a, b_req0_b, b_req1_a, b_req1_b;
    logic         b_resp0_valid, b_resp1_valid, b_resp0_ready, b_resp1_ready;
    logic [W-1:0] b_resp0_y, b_resp1_y;
    logic [2:0]   b_resp0_flags, b_resp1_flags;
    logic [3:0]   b_alu_op;
    logic [W-1:0] b_alu_a, b_alu_b, b_alu_y;
    logic         b_alu_z, b_alu_c, b_alu_v, b_busy, b_grant_id;

    alu16_sched #(.ALU_LAT(LAT_A), .W(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_y(resp0_y), .resp0_flags(resp0_flags),
        .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_y(resp1_y), .resp1_flags(resp1_flags),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_y(alu_y),
        .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v), .busy(busy), .grant_id(grant_id)
    );

    alu16_sched #(.ALU_LAT(LAT_B), .W(W)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(b_req0_valid), .req0_ready(b_req0_ready), .req0_op(b_req0_op), .req0_a(b_req0_a), .req0_b(b_req0_b),
        .req1_valid(b_req1_valid), .req1_ready(b_req1_ready), .req1_op(b_req1_op), .req1_a(b_req1_a), .req1_b(b_req1_b),
        .resp0_valid(b_resp0_valid), .resp0_ready(b_resp0_ready), .resp0_y(b_resp0_y), .resp0_flags(b_resp0_flags),
        .resp1_valid(b_resp1_valid), .resp1_ready(b_resp1_ready), .resp1_y(b_resp1_y), .resp1_flags(b_resp1_flags),
        .alu_op(b_alu_op), .alu_a(b_alu_a), .alu_b(b_alu_b), .alu_y(b_alu_y),
        .alu_z(b_alu_z), .alu_c(b_alu_c), .alu_v(b_alu_v), .busy(b_busy), .grant_id(b_grant_id)
    );

    // alu16 behaviour: returns {y, z, c, v}
    function automatic logic [18:0] alu_fn(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        logic [15:0] y;
        logic        c, v;
        s = 17'd0; c = 1'b0; v = 1'b0;
        case (op)
            4'd0: begin s = {1'b0, a} + {1'b0, b}; y = s[15:0]; c = s[16];
                        v = (a[15] == b[15]) && (y[15] != a[15]); end
            4'd1: begin y = a - b; c = (a < b); v = (a[15] != b[15]) && (y[15] != a[15]); end
            4'd2: y = a & b;
            4'd3: y = a | b;
            4'd4: y = a ^ b;
            4'd5: y = ~a;
            4'd6: begin y = {a[14:0], 1'b0}; c = a[15]; end
            4'd7: begin y = {1'b0, a[15:1]}; c = a[0]; end
            default: y = a;
        endcase
        return {y, (y == 16'd0), c, v};
    endfunction

    // ALU models with LAT_A / LAT_B register stages behind the operand ports
    logic [18:0] pa [0:15];
    logic [18:0] pb [0:15];
    always @(posedge clk) begin
        pa[0] <= alu_fn(alu_op, alu_a, alu_b);
        pb[0] <= alu_fn(b_alu_op, b_alu_a, b_alu_b);
        for (int i = 1; i < 16; i++) begin
            pa[i] <= pa[i-1];
            pb[i] <= pb[i-1];
        end
    end
    assign {alu_y, alu_z, alu_c, alu_v}         = pa[LAT_A-1];
    assign {b_alu_y, b_alu_z, b_alu_c, b_alu_v} = pb[LAT_B-1];

    // Transaction model: an operation accepted at the end of cycle m_acc
    // presents its response from cycle m_acc+LAT+2 until it is taken.
    int          cyc = 0;
    int          m_acc;
    logic        m_inflight, m_last, m_gid;
    logic [3:0]  m_op;
    logic [15:0] m_a, m_b;
    logic [18:0] m_res;
    logic [15:0] m_y [0:1];
    logic [2:0]  m_f [0:1];
    logic        e_ready0, e_ready1, e_rv;

    assign e_ready0 = !m_inflight && req0_valid && (!req1_valid || m_last);
    assign e_ready1 = !m_inflight && req1_valid && (!req0_valid || !m_last);
    assign e_rv     = m_inflight && (cyc >= m_acc + LAT_A + 2);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n) begin
            m_inflight <= 1'b0; m_last <= 1'b1; m_gid <= 1'b0; m_acc <= 0;
            m_op <= 4'd0; m_a <= 16'd0; m_b <= 16'd0; m_res <= 19'd0;
            m_y[0] <= 16'd0; m_y[1] <= 16'd0; m_f[0] <= 3'd0; m_f[1] <= 3'd0;
        end else if (!m_inflight) begin
            if (e_ready0 || e_ready1) begin
                m_inflight <= 1'b1; m_acc <= cyc; m_gid <= e_ready1; m_last <= e_ready1;
                m_op  <= e_ready1 ? req1_op : req0_op;
                m_a   <= e_ready1 ? req1_a  : req0_a;
                m_b   <= e_ready1 ? req1_b  : req0_b;
                m_res <= e_ready1 ? alu_fn(req1_op, req1_a, req1_b) : alu_fn(req0_op, req0_a, req0_b);
            end
        end else begin
            if (cyc == m_acc + LAT_A + 1) begin
                m_y[m_gid] <= m_res[18:3];
                m_f[m_gid] <= m_res[2:0];
            end
            if (e_rv && (m_gid ? resp1_ready : resp0_ready)) m_inflight <= 1'b0;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("req0_ready",  32'(req0_ready),  32'(e_ready0));
            chk("req1_ready",  32'(req1_ready),  32'(e_ready1));
            chk("busy",        32'(busy),        32'(m_inflight));
            chk("grant_id",    32'(grant_id),    32'(m_gid));
            chk("alu_op",      32'(alu_op),      32'(m_op));
            chk("alu_a",       32'(alu_a),       32'(m_a));
            chk("alu_b",       32'(alu_b),       32'(m_b));
            chk("resp0_valid", 32'(resp0_valid), 32'(e_rv && !m_gid));
            chk("resp1_valid", 32'(resp1_valid), 32'(e_rv && m_gid));
            chk("resp0_y",     32'(resp0_y),     32'(m_y[0]));
            chk("resp1_y",     32'(resp1_y),     32'(m_y[1]));
            chk("resp0_flags", 32'(resp0_flags), 32'(m_f[0]));
            chk("resp1_flags", 32'(resp1_flags), 32'(m_f[1]));
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0; req0_op = 4'd0; req0_a = '0; req0_b = '0;
        req1_valid = 1'b0; req1_op = 4'd0; req1_a = '0; req1_b = '0;
        resp0_ready = 1'b1; resp1_ready = 1'b1;
        b_req0_valid = 1'b0; b_req0_op = 4'd0; b_req0_a = '0; b_req0_b = '0;
        b_req1_valid = 1'b0; b_req1_op = 4'd0; b_req1_a = '0; b_req1_b = '0;
        b_resp0_ready = 1'b1; b_resp1_ready = 1'b1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        nxt(); nxt();
        rst_n = 1'b1;
    endtask

    task automatic wait_resp(input int n, output logic [15:0] y, output logic [2:0] f);
        bit got;
        got = 1'b0;
        for (int k = 0; k < 30; k++) begin
            mid();
            if ((n == 0) ? resp0_valid : resp1_valid) begin
                got = 1'b1;
                break;
            end
            nxt();
        end
        chk("wait_resp_timeout", 32'(got), 32'd1);
        y = (n == 0) ? resp0_y : resp1_y;
        f = (n == 0) ? resp0_flags : resp1_flags;
    endtask

    function automatic logic [15:0] rnd16();
        case ($urandom_range(0, 7))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h8000;
            3: return 16'h7FFF;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [15:0] y;
    logic [2:0]  f;
    logic        order [0:3];
    bit          hs0, hs1, got;

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        nxt(); nxt(); nxt();
        chk_en = 1'b1;
        rst_n  = 1'b1;

        // reset values
        mid();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_grant_id", 32'(grant_id), 32'd0);
        chk("rst_resp0_valid", 32'(resp0_valid), 32'd0);
        nxt();

        // ALU_LAT=3: 0xFFFF+1 -> y=0, z=1, c=1, valid at T+5
        b_req1_valid = 1'b1; b_req1_op = 4'd0; b_req1_a = 16'hFFFF; b_req1_b = 16'h0001;
        mid();
        chk("l3_req1_ready", 32'(b_req1_ready), 32'd1);
        chk("l3_req0_ready", 32'(b_req0_ready), 32'd0);
        nxt();
        b_req1_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            mid();
            chk("l3_resp1_early", 32'(b_resp1_valid), 32'd0);
            chk("l3_busy", 32'(b_busy), 32'd1);
            nxt();
        end
        mid();
        chk("l3_resp1_valid", 32'(b_resp1_valid), 32'd1);
        chk("l3_resp1_y", 32'(b_resp1_y), 32'h0000);
        chk("l3_resp1_flags", 32'(b_resp1_flags), 32'b110);
        chk("l3_grant_id", 32'(b_grant_id), 32'd1);
        chk("l3_alu_a", 32'(b_alu_a), 32'hFFFF);
        chk("l3_resp0_valid", 32'(b_resp0_valid), 32'd0);
        nxt();
        mid();
        chk("l3_after_valid", 32'(b_resp1_valid), 32'd0);
        chk("l3_after_busy", 32'(b_busy), 32'd0);
        chk("l3_resp0_y", 32'({b_resp0_y, b_resp0_flags}), 32'd0);
        nxt();

        // single request, 1+2
        req0_valid = 1'b1; req0_op = 4'd0; req0_a = 16'h0001; req0_b = 16'h0002;
        mid();
        chk("t1_ready0", 32'(req0_ready), 32'd1);
        nxt();
        req0_valid = 1'b0;
        mid();
        chk("t1_busy_t1", 32'(busy), 32'd1);
        chk("t1_valid_t1", 32'(resp0_valid), 32'd0);
        nxt(); mid();
        chk("t1_valid_t2", 32'(resp0_valid), 32'd0);
        nxt(); mid();
        chk("t1_valid_t3", 32'(resp0_valid), 32'd1);
        chk("t1_y", 32'(resp0_y), 32'h0003);
        chk("t1_flags", 32'(resp0_flags), 32'd0);
        chk("t1_resp1_valid", 32'(resp1_valid), 32'd0);
        chk("t1_busy_t3", 32'(busy), 32'd1);
        nxt(); mid();
        chk("t1_valid_t4", 32'(resp0_valid), 32'd0);
        chk("t1_busy_t4", 32'(busy), 32'd0);
        nxt();

        // simultaneous first requests
        do_reset();
        req0_valid = 1'b1; req0_op = 4'd0; req0_a = 16'h0001; req0_b = 16'h0002;
        req1_valid = 1'b1; req1_op = 4'd1; req1_a = 16'h0003; req1_b = 16'h0001;
        mid();
        chk("t2_ready0", 32'(req0_ready), 32'd1);
        chk("t2_ready1", 32'(req1_ready), 32'd0);
        nxt();
        req0_valid = 1'b0;
        wait_resp(0, y, f);
        chk("t2_y0", 32'(y), 32'h0003);
        nxt(); mid();
        chk("t2_ready1_next", 32'(req1_ready), 32'd1);
        nxt();
        req1_valid = 1'b0;
        mid();
        chk("t2_grant_id", 32'(grant_id), 32'd1);
        nxt();
        wait_resp(1, y, f);
        chk("t2_y1", 32'(y), 32'h0002);
        chk("t2_f1", 32'(f), 32'd0);
        nxt();

        // fairness with both requesters always valid
        do_reset();
        req0_valid = 1'b1; req0_op = 4'd0; req0_a = 16'h0010; req0_b = 16'h0020;
        req1_valid = 1'b1; req1_op = 4'd3; req1_a = 16'h0F00; req1_b = 16'h00F0;
        for (int k = 0; k < 4; k++) begin
            got = 1'b0;
            order[k] = 1'b0;
            for (int j = 0; j < 30; j++) begin
                mid();
                if (req0_ready || req1_ready) begin
                    order[k] = req1_ready;
                    got = 1'b1;
                    break;
                end
                nxt();
            end
            chk("fair_timeout", 32'(got), 32'd1);
            nxt();
            if (order[k]) begin req1_op = 4'($urandom_range(0, 7)); req1_a = rnd16(); req1_b = rnd16(); end
            else          begin req0_op = 4'($urandom_range(0, 7)); req0_a = rnd16(); req0_b = rnd16(); end
        end
        chk("fair_0", 32'(order[0]), 32'd0);
        chk("fair_1", 32'(order[1]), 32'd1);
        chk("fair_2", 32'(order[2]), 32'd0);
        chk("fair_3", 32'(order[3]), 32'd1);
        req0_valid = 1'b0; req1_valid = 1'b0;
        for (int k = 0; k < 6; k++) nxt();

        // backpressure on resp0 for 5 cycles
        do_reset();
        resp0_ready = 1'b0;
        req0_valid = 1'b1; req0_op = 4'd2; req0_a = 16'hF0F0; req0_b = 16'h0FF0;
        mid();
        nxt();
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_op = 4'd4; req1_a = 16'h1234; req1_b = 16'h00FF;
        wait_resp(0, y, f);
        chk("bp_y", 32'(y), 32'h00F0);
        chk("bp_f", 32'(f), 32'd0);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) mid();
            chk("bp_valid_hold", 32'(resp0_valid), 32'd1);
            chk("bp_y_hold", 32'(resp0_y), 32'(y));
            chk("bp_f_hold", 32'(resp0_flags), 32'(f));
            chk("bp_req1_ready", 32'(req1_ready), 32'd0);
            nxt();
        end
        resp0_ready = 1'b1;
        mid();
        chk("bp_valid_last", 32'(resp0_valid), 32'd1);
        chk("bp_req1_ready_last", 32'(req1_ready), 32'd0);
        nxt(); mid();
        chk("bp_idle_busy", 32'(busy), 32'd0);
        chk("bp_idle_ready1", 32'(req1_ready), 32'd1);
        nxt();
        req1_valid = 1'b0;
        wait_resp(1, y, f);
        chk("bp_y1", 32'(y), 32'h12CB);
        nxt();

        // reset one cycle after accept
        do_reset();
        req0_valid = 1'b1; req0_op = 4'd0; req0_a = 16'h0005; req0_b = 16'h0006;
        mid();
        nxt();
        req0_valid = 1'b0;
        rst_n = 1'b0;
        mid();
        nxt();
        rst_n = 1'b1;
        mid();
        chk("rw_busy", 32'(busy), 32'd0);
        chk("rw_resp0_valid", 32'(resp0_valid), 32'd0);
        chk("rw_alu_a", 32'(alu_a), 32'd0);
        chk("rw_resp0_y", 32'(resp0_y), 32'd0);
        for (int k = 0; k < 4; k++) begin
            nxt(); mid();
            chk("rw_no_resp", 32'(resp0_valid || resp1_valid), 32'd0);
        end
        nxt();
        req1_valid = 1'b1; req1_op = 4'd1; req1_a = 16'd10; req1_b = 16'd3;
        mid();
        chk("rw_ready1", 32'(req1_ready), 32'd1);
        nxt();
        req1_valid = 1'b0;
        wait_resp(1, y, f);
        chk("rw_y1", 32'(y), 32'd7);
        nxt();

        // randomized traffic with occasional resets
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            hs0 = req0_valid && req0_ready && rst_n;
            hs1 = req1_valid && req1_ready && rst_n;
            @(posedge clk);
            #1;
            if (!rst_n) rst_n = 1'b1;
            else if ($urandom_range(0, 299) == 0) rst_n = 1'b0;
            if (hs0 || !req0_valid) begin
                req0_valid = ($urandom_range(0, 99) < 40);
                req0_op = 4'($urandom_range(0, 15)); req0_a = rnd16(); req0_b = rnd16();
            end
            if (hs1 || !req1_valid) begin
                req1_valid = ($urandom_range(0, 99) < 40);
                req1_op = 4'($urandom_range(0, 15)); req1_a = rnd16(); req1_b = rnd16();
            end
            resp0_ready = ($urandom_range(0, 99) < 60);
            resp1_ready = ($urandom_range(0, 99) < 60);
        end
        rst_n = 1'b1;
        idle_inputs();
        for (int k = 0; k < 10; k++) nxt();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/alu16_sched.md
Name: alu16_sched

Overview:
- Two-requester scheduler that shares one alu16 instance between requesters via valid/ready handshakes.
- Arbitrates round-robin, issues the winner's op/a/b to the ALU, and holds the operands stable for the ALU pipeline latency.
- Captures y/z/c/v and returns them on the winner's response channel.
- Sits between the stimulus/agent ports and the alu16 datapath. One operation is in flight at a time.

Parameters:
- ALU_LAT, 1, cycles from operands sampled by alu16 to y/z/c/v valid. Legal range 0..15.
- W, 16, data width of a/b/y.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous active-low reset
- req0_valid / req1_valid  in  1  request present
- req0_ready / req1_ready  out  1  request accepted this cycle (combinational)
- req0_op / req1_op  in  4  ALU opcode
- req0_a, req0_b / req1_a, req1_b  in  W  operands
- resp0_valid / resp1_valid  out  1  result available
- resp0_ready / resp1_ready  in  1  consumer accepts result
- resp0_y / resp1_y  out  W  ALU result
- resp0_flags / resp1_flags  out  3  {z,c,v}
- alu_op  out  4  to alu16.op
- alu_a, alu_b  out  W  to alu16.a/.b
- alu_y  in  W  from alu16.y
- alu_z, alu_c, alu_v  in  1  from alu16 flags
- busy  out  1  high in any state other than IDLE
- grant_id  out  1  requester owning the current operation

Behaviour:
- States: IDLE, WAIT, RESP. Reset state is IDLE.
- Reset values:
  - All outputs 0.
  - Round-robin pointer last_grant=1, so requester 0 wins the first tie.
  - Latency counter cnt=0.
- IDLE arbitration:
  - If exactly one reqN_valid is high, grant N.
  - If both are high, grant the requester that is not last_grant.
  - reqN_ready=1 only for the granted requester, only in IDLE. Otherwise it is 0.
  - Handshake occurs at the edge where reqN_valid and reqN_ready are both high (cycle T).
- At that edge:
  - Register op/a/b into alu_op/alu_a/alu_b.
  - Set grant_id=N, last_grant=N, cnt=ALU_LAT.
  - Go to WAIT.
- alu_op/alu_a/alu_b change only at an accept edge; they hold their value in all other cycles.
- WAIT:
  - If cnt!=0, decrement cnt.
  - If cnt==0, register alu_y/alu_z/alu_c/alu_v into the grant_id response registers and go to RESP.
- With ALU_LAT=1:
  - Capture at the end of T+2.
  - respN_valid first high in cycle T+3.
  - General rule: respN_valid rises ALU_LAT+2 cycles after the accept edge.
- RESP:
  - respN_valid=1 for N=grant_id. The other resp_valid stays 0.
  - y/flags are held stable.
  - On the edge where respN_ready=1, clear respN_valid and go to IDLE.
  - The next accept can occur at the earliest in the following cycle.
- resp_y/resp_flags keep their last captured value after valid drops.
- A req_valid asserted during WAIT/RESP is not accepted and sees ready=0. Requesters must hold op/a/b stable until ready.
- If respN_ready is already high when valid rises, the handshake completes in that same cycle; valid is high for exactly 1 cycle.
- Reset mid-operation (rst_n=0 at any edge): immediate return to reset values. The in-flight result is discarded and no response is issued.
- No arithmetic is performed in this block. Widths pass through unchanged, and the opcode is forwarded unmodified.

Test Plan:
- Single request, ALU_LAT=1:
  - Stimulus: req0 op=0, a=0x0001, b=0x0002, resp0_ready=1; accept at T.
  - Response: resp0_valid high in T+3 for 1 cycle, resp0_y=0x0003, flags z=0; resp1_valid stays 0; busy high T+1..T+3.
- Simultaneous first requests:
  - Stimulus: both valid right after reset, req0 op=0 1+2, req1 op=1 3-1.
  - Response: req0 granted first (resp0_y=0x0003); req1 granted in the next IDLE (resp1_y=0x0002, grant_id=1).
- Fairness:
  - Stimulus: both valid continuously for 4 operations.
  - Response: grant order 0,1,0,1; no starvation.
- Backpressure:
  - Stimulus: resp0_ready held low 5 cycles after resp0_valid rises.
  - Response: resp0_valid, y and flags stable all 5 cycles; req1_ready=0 throughout; IDLE is reached only after the ready edge.
- Reset mid-WAIT:
  - Stimulus: drive rst_n=0 one cycle after accept.
  - Response: next cycle all outputs 0, busy=0, no resp_valid; a subsequent req1-only request is granted normally.
- ALU_LAT=3 build:
  - Stimulus: req1 op=0, a=0xFFFF, b=0x0001.
  - Response: resp1_valid first high at T+5 with resp1_y equal to the ALU model output (0x0000) and z=1.
